// File: rtl/rv32_issue_scoreboard.sv
// rv32_issue_scoreboard: holds decoded instructions back on RAW/WAW hazards and issues them through a one-entry buffer
module rv32_issue_scoreboard #(
  parameter int PEND_WIDTH   = 2,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [31:0]                       in_inst,
  input  logic [4:0]                        in_rd,
  input  logic [4:0]                        in_rs1,
  input  logic [4:0]                        in_rs2,
  input  logic                              in_uses_rs1,
  input  logic                              in_uses_rs2,
  input  logic                              in_writes_rd,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [31:0]                       out_inst,
  output logic [4:0]                        out_rd,
  output logic                              out_writes_rd,
  input  logic                              wb_valid,
  input  logic [4:0]                        wb_rd,
  input  logic                              flush,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_count
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  logic [PEND_WIDTH-1:0] cnt [32];
  logic [31:0] pend;
  logic wr_eff, wb_ret, hazard, full, acc;
  always_comb begin
    for (int i = 0; i < 32; i++)
      pend[i] = cnt[i] != '0 && !(wb_valid && wb_rd == 5'(i) && cnt[i] == PEND_WIDTH'(1));
    wr_eff   = in_writes_rd && in_rd != 5'd0;
    wb_ret   = wb_valid && wb_rd != 5'd0 && cnt[wb_rd] != '0;
    hazard   = (in_uses_rs1 && pend[in_rs1]) || (in_uses_rs2 && pend[in_rs2]) || (wr_eff && pend[in_rd]);
    full     = wr_eff && ((inflight_count - CW'(wb_ret)) >= CW'(MAX_INFLIGHT) || &cnt[in_rd]);
    in_ready = !rst && !flush && !hazard && !full && (!out_valid || out_ready);
    acc      = in_valid && in_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      inflight_count <= '0;
      out_valid      <= 1'b0;
      out_inst       <= '0;
      out_rd         <= '0;
      out_writes_rd  <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      inflight_count <= '0;
      out_valid      <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++)
        cnt[i] <= cnt[i] + PEND_WIDTH'(acc && wr_eff && in_rd == 5'(i)) - PEND_WIDTH'(wb_ret && wb_rd == 5'(i));
      inflight_count <= inflight_count + CW'(acc && wr_eff) - CW'(wb_ret);
      if (acc) begin
        out_valid     <= 1'b1;
        out_inst      <= in_inst;
        out_rd        <= in_rd;
        out_writes_rd <= wr_eff;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rv32_issue_scoreboard.sv
// tb_rv32_issue_scoreboard: directed table-driven check of the issue scoreboard
module tb_rv32_issue_scoreboard;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid, in_ready, in_uses_rs1, in_uses_rs2, in_writes_rd;
  logic [31:0] in_inst, out_inst;
  logic [4:0] in_rd, in_rs1, in_rs2, out_rd, wb_rd;
  logic out_valid, out_ready, out_writes_rd, wb_valid, flush;
  logic [3:0] inflight_count;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  rv32_issue_scoreboard dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_uses_rs1(in_uses_rs1),
    .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_rd(out_rd), .out_writes_rd(out_writes_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .inflight_count(inflight_count)
  );
  typedef struct {
    logic        iv;
    logic [31:0] inst;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2, w, ordy, wbv;
    logic [4:0]  wbrd;
    logic        fl, e_rdy, e_ov;
    logic [31:0] e_inst;
    logic [4:0]  e_rd;
    logic        e_wr;
    logic [3:0]  e_infl;
  } vec_t;
  vec_t v [22];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic iv, input logic [31:0] inst, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2, input logic w, input logic ordy,
                       input logic wbv, input logic [4:0] wbrd, input logic fl);
    in_valid = iv; in_inst = inst; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_uses_rs1 = u1; in_uses_rs2 = u2; in_writes_rd = w; out_ready = ordy;
    wb_valid = wbv; wb_rd = wbrd; flush = fl;
  endtask
  initial begin
    //        iv inst   rd rs1 rs2 u1 u2 w ordy wbv wbrd fl | rdy ov inst  rd wr infl
    v[0]  = '{1, 32'hA1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0,  1, 1, 32'hA1, 1, 1, 1};
    v[1]  = '{1, 32'hA2, 4, 5, 6, 1, 1, 1, 1, 0, 0, 0,  1, 1, 32'hA2, 4, 1, 2};
    v[2]  = '{1, 32'hA3, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 1, 32'hA3, 5, 1, 3};
    v[3]  = '{1, 32'hA4, 7, 5, 0, 1, 1, 1, 1, 0, 0, 0,  0, 0, 32'h0, 0, 0, 3};
    v[4]  = '{1, 32'hA4, 7, 5, 0, 1, 1, 1, 1, 0, 0, 0,  0, 0, 32'h0, 0, 0, 3};
    v[5]  = '{1, 32'hA4, 7, 5, 0, 1, 1, 1, 1, 1, 5, 0,  1, 1, 32'hA4, 7, 1, 3};
    v[6]  = '{1, 32'hA5, 9, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 1, 32'hA5, 9, 1, 4};
    v[7]  = '{1, 32'hA6, 9, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 32'h0, 0, 0, 4};
    v[8]  = '{1, 32'hA6, 9, 0, 0, 0, 0, 1, 1, 1, 9, 0,  1, 1, 32'hA6, 9, 1, 4};
    v[9]  = '{1, 32'hA7, 0, 9, 0, 1, 0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0, 0, 4};
    v[10] = '{0, 32'h0,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  1, 0, 32'h0, 0, 0, 4};
    v[11] = '{0, 32'h0,  0, 0, 0, 0, 0, 0, 1, 1, 20, 0, 1, 0, 32'h0, 0, 0, 4};
    v[12] = '{1, 32'hB1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 32'hB1, 0, 0, 4};
    v[13] = '{1, 32'hB2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'hB1, 0, 0, 4};
    v[14] = '{1, 32'hB2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'hB1, 0, 0, 4};
    v[15] = '{1, 32'hB2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'hB1, 0, 0, 4};
    v[16] = '{1, 32'hB2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 32'hB2, 0, 0, 4};
    v[17] = '{1, 32'hC1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0, 0, 4};
    v[18] = '{1, 32'hC1, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1,  0, 0, 32'h0, 0, 0, 0};
    v[19] = '{1, 32'hC1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0,  1, 1, 32'hC1, 0, 0, 0};
    v[20] = '{1, 32'hC2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 1, 32'hC2, 0, 0, 0};
    v[21] = '{0, 32'h0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 32'h0, 0, 0, 0};
    drive(1, 32'hDEAD, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_rd", 32'(out_rd), 0);
    chk("rst_out_wr", 32'(out_writes_rd), 0);
    chk("rst_inflight", 32'(inflight_count), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 22; k++) begin
      drive(v[k].iv, v[k].inst, v[k].rd, v[k].rs1, v[k].rs2, v[k].u1, v[k].u2, v[k].w,
            v[k].ordy, v[k].wbv, v[k].wbrd, v[k].fl);
      #1;
      chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(v[k].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(v[k].e_ov));
      chk($sformatf("v%0d_inflight", k), 32'(inflight_count), 32'(v[k].e_infl));
      if (v[k].e_ov) begin
        chk($sformatf("v%0d_out_inst", k), out_inst, v[k].e_inst);
        chk($sformatf("v%0d_out_rd", k), 32'(out_rd), 32'(v[k].e_rd));
        chk($sformatf("v%0d_out_wr", k), 32'(out_writes_rd), 32'(v[k].e_wr));
      end
      @(negedge clk);
    end
    for (int r = 1; r <= 8; r++) begin
      drive(1, 32'h100 + 32'(r), 5'(r), 0, 0, 0, 0, 1, 1, 0, 0, 0);
      #1;
      chk($sformatf("fill%0d_in_ready", r), 32'(in_ready), 1);
      @(negedge clk);
    end
    chk("fill_inflight", 32'(inflight_count), 8);
    drive(1, 32'h10A, 10, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    #1;
    chk("max_writer_ready", 32'(in_ready), 0);
    @(negedge clk);
    drive(1, 32'h1F0, 0, 20, 0, 1, 0, 0, 1, 0, 0, 0);
    #1;
    chk("max_reader_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("max_reader_inst", out_inst, 32'h1F0);
    chk("max_reader_inflight", 32'(inflight_count), 8);
    @(negedge clk);
    drive(1, 32'h10A, 10, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    #1;
    chk("max_wb_bypass_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("max_wb_bypass_inst", out_inst, 32'h10A);
    chk("max_wb_bypass_inflight", 32'(inflight_count), 8);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    @(posedge clk); #1;
    chk("final_flush_inflight", 32'(inflight_count), 0);
    chk("final_flush_valid", 32'(out_valid), 0);
    @(negedge clk);
    drive(1, 32'h1F1, 3, 10, 8, 1, 1, 1, 1, 0, 0, 0);
    #1;
    chk("post_flush_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("post_flush_inflight", 32'(inflight_count), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32_issue_scoreboard.md
Name: rv32_issue_scoreboard

Overview:
- Issue-stage controller between rv32 decode and execute.
- Tracks outstanding register writes per architectural register. Holds back decoded instructions whose source or destination registers are pending (RAW/WAW hazards).
- Releases them through a one-entry registered issue buffer.
- Writeback retires pending writes. Flush clears all tracking state.

Parameters:
- PEND_WIDTH, 2, width of each per-register pending counter; max outstanding writes per register = 2^PEND_WIDTH-1.
- MAX_INFLIGHT, 8, max total instructions issued with writes_rd=1 and not yet written back.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  decoded instruction valid
- in_ready  output  1  scoreboard accepts instruction this cycle
- in_inst  input  32  raw instruction word
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_uses_rs1  input  1  instruction reads rs1
- in_uses_rs2  input  1  instruction reads rs2
- in_writes_rd  input  1  instruction writes rd
- out_valid  output  1  issue buffer holds instruction
- out_ready  input  1  execute consumes buffer
- out_inst  output  32  buffered instruction word
- out_rd  output  5  buffered rd
- out_writes_rd  output  1  buffered writes_rd
- wb_valid  input  1  writeback retires one write
- wb_rd  input  5  register being written back
- flush  input  1  discard buffer and all pending state
- inflight_count  output  $clog2(MAX_INFLIGHT+1)  current outstanding writes

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - all pending counters = 0; inflight_count = 0; out_valid = 0
  - out_inst/out_rd/out_writes_rd = 0
  - in_ready = 0 during the reset cycle
- Register x0: never pending. Reads/writes of x0 never hazard, never counted. An instruction with writes_rd=1 and rd=0 issues as writes_rd=0 internally.
- pend(r): true when counter[r] != 0 and not (wb_valid && wb_rd==r && counter[r]==1). Same-cycle writeback bypasses the hazard.
- hazard = (uses_rs1 && pend(rs1)) || (uses_rs2 && pend(rs2)) || (writes_rd && pend(rd)). WAW is stalled so writebacks stay in order per register.
- full = writes_rd && rd!=0 && (inflight_count==MAX_INFLIGHT, less 1 if wb_valid && wb_rd!=0 that cycle) reaches MAX_INFLIGHT; also counter[rd] saturated.
- in_ready = !rst && !flush && !hazard && !full && (!out_valid || out_ready). Combinational from inputs; no dependence of in_valid on in_ready.
- Accept: in_valid && in_ready. Next cycle:
  - out_valid=1 and out_* loaded (latency 1)
  - counter[rd]++ and inflight_count++ if writes_rd && rd!=0
- Consume: out_valid && out_ready && !accept gives out_valid=0 next cycle. Accept and consume in the same cycle gives back-to-back issue at 1/cycle.
- Writeback: wb_valid && wb_rd!=0 gives counter[wb_rd]-- and inflight_count--.
  - Writeback to a register with counter 0: ignored, no underflow.
  - Writeback to x0: ignored.
- Simultaneous accept and writeback on the same register: counter net unchanged; inflight_count net unchanged.
- out_* stable while out_valid && !out_ready.
- flush (higher priority than everything except rst):
  - next cycle: out_valid=0, all counters=0, inflight_count=0
  - in_ready=0 and wb ignored in the flush cycle

Test Plan:
- Reset, then independent stream `add x1,x2,x3` / `add x4,x5,x6` with out_ready=1 -> out_valid at cycle+1; both issue on consecutive cycles; counter[1]=counter[4]=1; inflight_count=2.
- Issue writes x5, then `add x7,x5,x0` (uses_rs1) -> in_ready=0. Hold until wb_valid=1, wb_rd=5 in the same cycle -> in_ready=1 that cycle; x7 issues; counter[5]=0.
- Writer to x9 pending, second writer to x9 presented -> stalled (WAW) until wb x9; then accepted; counter[9]=1.
- MAX_INFLIGHT=8: issue 8 writers to x1..x8 with no wb; 9th writer to x10 -> in_ready=0. Non-writer reading x20 -> accepted.
- out_ready=0 with out_valid=1 for 3 cycles -> out_inst unchanged; in_ready=0. Release -> next instruction loads the following cycle.
- Three writers pending, flush=1 with in_valid=1 and wb_valid=1 -> next cycle out_valid=0, inflight_count=0; the previously hazarding reader is accepted immediately. Also: wb to x0 or an idle register leaves all counters at 0.
